// File: rtl/draw_rect_ctl.sv
// draw_rect_ctl
//   Position controller between the mouse-position delay register and the
//   rectangle renderer (VGA pixel clock domain). In IDLE the rectangle
//   follows the delayed mouse position. A left-button press drops it: it
//   falls under constant acceleration (one velocity step per physics tick)
//   until it reaches the screen bottom, then holds. A press while landed
//   returns to tracking.
//
//   Optional feature macro: RECT_BOUNCE_EN
//     When defined, bottom contact with enough speed bounces the rectangle
//     up (state RISE) at half the impact speed, repeating until the rebound
//     speed drops below 2 px/tick.
//
// Ports
//   clk         in   pixel clock
//   rst         in   asynchronous active-low reset
//   xpos_in     in   [11:0] delayed mouse x
//   ypos_in     in   [11:0] delayed mouse y
//   mouse_left  in   left button level, synchronous to clk
//   xpos_out    out  [11:0] rectangle x (registered)
//   ypos_out    out  [11:0] rectangle y (registered)
//   falling     out  high while falling (or rising when bouncing)
//   fsm_state   out  [1:0] debug view of the controller state
//                    (0 IDLE, 1 FALL, 2 LANDED, 3 RISE)
//
// Interface timing: no handshakes; all inputs are sampled every cycle and
// all outputs are registered, changing only on the rising clock edge.

module draw_rect_ctl #(
   parameter int TICK_DIV      = 400000,
   parameter int RECT_HEIGHT   = 64,
   parameter int SCREEN_HEIGHT = 600,
   parameter int GRAVITY       = 1,
   parameter int VMAX          = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] xpos_in,
   input  logic [11:0] ypos_in,
   input  logic        mouse_left,
   output logic [11:0] xpos_out,
   output logic [11:0] ypos_out,
   output logic        falling,
   output logic [1:0]  fsm_state
);

   localparam int          CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [12:0] BOTTOM   = 13'(SCREEN_HEIGHT - RECT_HEIGHT);
   localparam logic [11:0] BOTTOM12 = 12'(SCREEN_HEIGHT - RECT_HEIGHT);
   localparam logic [12:0] GRAV     = 13'(GRAVITY);
   localparam logic [12:0] VLIM     = 13'(VMAX);

`ifdef RECT_BOUNCE_EN
   typedef enum logic [1:0] {IDLE = 2'd0, FALL = 2'd1, LANDED = 2'd2, RISE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, FALL = 2'd1, LANDED = 2'd2} state_t;
`endif

   state_t        state;
   logic [CW-1:0] tick_cnt;
   logic          tick;
   logic          mouse_left_q;
   logic          press;
   logic [12:0]   vel;
   logic [12:0]   v_sum;
   logic [12:0]   v_next;
   logic [12:0]   y_sum;
   logic [12:0]   y_in_ext;
   logic [11:0]   y_track;

   assign fsm_state = state;
   assign press     = mouse_left & ~mouse_left_q;
   assign tick      = (tick_cnt == TICK_LAST);

   // 13-bit physics arithmetic: a 12-bit position plus a capped velocity
   // cannot wrap, so the floor comparison is always exact.
   assign v_sum    = vel + GRAV;
   assign v_next   = (v_sum > VLIM) ? VLIM : v_sum;
   assign y_sum    = {1'b0, ypos_out} + v_next;
   assign y_in_ext = {1'b0, ypos_in};
   assign y_track  = (y_in_ext > BOTTOM) ? BOTTOM12 : ypos_in;

`ifdef RECT_BOUNCE_EN
   logic [12:0] vb;
   logic [11:0] y_up;
   assign vb   = v_next >> 1;
   // Rising position is floored at the top of the screen.
   assign y_up = (vel >= {1'b0, ypos_out}) ? 12'd0 : (ypos_out - vel[11:0]);
`endif

   // Free-running physics tick, independent of the controller state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         xpos_out     <= '0;
         ypos_out     <= '0;
         vel          <= '0;
         falling      <= 1'b0;
         mouse_left_q <= 1'b0;
      end else begin
         mouse_left_q <= mouse_left;
         case (state)
            IDLE: begin
               // Positions load even on the press cycle; that load is the
               // frozen start point of the fall. Ticks are ignored here.
               xpos_out <= xpos_in;
               ypos_out <= y_track;
               vel      <= '0;
               if (press) begin
                  state   <= FALL;
                  falling <= 1'b1;
               end
            end
            FALL: begin
               if (tick) begin
                  if (y_sum >= BOTTOM) begin
                     ypos_out <= BOTTOM12;
`ifdef RECT_BOUNCE_EN
                     if (vb >= 13'd2) begin
                        vel   <= vb;
                        state <= RISE;
                     end else begin
                        vel     <= '0;
                        state   <= LANDED;
                        falling <= 1'b0;
                     end
`else
                     vel      <= '0;
                     state    <= LANDED;
                     falling  <= 1'b0;
`endif
                  end else begin
                     vel      <= v_next;
                     ypos_out <= y_sum[11:0];
                  end
               end
            end
            LANDED: begin
               if (press) begin
                  state <= IDLE;
               end
            end
`ifdef RECT_BOUNCE_EN
            RISE: begin
               if (tick) begin
                  if (vel <= GRAV) begin
                     vel   <= '0;
                     state <= FALL;
                  end else begin
                     ypos_out <= y_up;
                     vel      <= vel - GRAV;
                  end
               end
            end
`endif
            default: begin
               state   <= IDLE;
               falling <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Testbench for draw_rect_ctl with TICK_DIV=4. A trajectory model computes
// the expected rectangle position each cycle from the button/tick rules;
// a compare process checks the DUT against it on every falling edge, and
// directed scenarios pin the model with literal expected values.

module tb_draw_rect_ctl;

   localparam int TICK_DIV = 4;
   localparam int BOTTOM   = 600 - 64;
   localparam int GRAVITY  = 1;
   localparam int VMAX     = 64;

   localparam int MS_IDLE = 0, MS_FALL = 1, MS_LANDED = 2, MS_RISE = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] xpos_in = '0;
   logic [11:0] ypos_in = '0;
   logic        mouse_left = 1'b0;
   logic [11:0] xpos_out;
   logic [11:0] ypos_out;
   logic        falling;
   logic [1:0]  fsm_state;

   int n_checks = 0;
   int n_pass   = 0;

   // model state
   int m_mode = MS_IDLE;
   int m_x = 0, m_y = 0, m_vel = 0;
   int m_cycles = 0;
   bit m_btn_prev = 1'b0;

   draw_rect_ctl #(.TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .rst(rst), .xpos_in(xpos_in), .ypos_in(ypos_in),
      .mouse_left(mouse_left), .xpos_out(xpos_out), .ypos_out(ypos_out),
      .falling(falling), .fsm_state(fsm_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- trajectory model ----------------
   // Ticks happen on every TICK_DIV-th clock edge counted from reset release.
   task automatic model_edge();
      bit pressed, is_tick;
      int vn;
      if (!rst) begin
         m_mode = MS_IDLE; m_x = 0; m_y = 0; m_vel = 0;
         m_cycles = 0; m_btn_prev = 1'b0;
         return;
      end
      is_tick    = ((m_cycles % TICK_DIV) == TICK_DIV - 1);
      m_cycles++;
      pressed    = mouse_left && !m_btn_prev;
      m_btn_prev = mouse_left;
      if (m_mode == MS_IDLE) begin
         m_x   = int'(xpos_in);
         m_y   = (int'(ypos_in) < BOTTOM) ? int'(ypos_in) : BOTTOM;
         m_vel = 0;
         if (pressed) m_mode = MS_FALL;
      end else if (m_mode == MS_LANDED) begin
         if (pressed) m_mode = MS_IDLE;
      end else if (m_mode == MS_FALL && is_tick) begin
         vn = (m_vel + GRAVITY > VMAX) ? VMAX : m_vel + GRAVITY;
         if (m_y + vn < BOTTOM) begin
            m_y   = m_y + vn;
            m_vel = vn;
         end else begin
            m_y = BOTTOM;
`ifdef RECT_BOUNCE_EN
            if (vn / 2 >= 2) begin m_vel = vn / 2; m_mode = MS_RISE; end
            else begin m_vel = 0; m_mode = MS_LANDED; end
`else
            m_vel  = 0;
            m_mode = MS_LANDED;
`endif
         end
      end else if (m_mode == MS_RISE && is_tick) begin
         if (m_vel <= GRAVITY) begin
            m_vel  = 0;
            m_mode = MS_FALL;
         end else begin
            m_y   = (m_vel >= m_y) ? 0 : m_y - m_vel;
            m_vel = m_vel - GRAVITY;
         end
      end
   endtask

   always @(posedge clk) model_edge();

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst) begin
         check("rst_x", int'(xpos_out), 0);
         check("rst_y", int'(ypos_out), 0);
         check("rst_falling", int'(falling), 0);
      end else begin
         check("model_x", int'(xpos_out), m_x);
         check("model_y", int'(ypos_out), m_y);
         check("model_falling", int'(falling),
               (m_mode == MS_FALL || m_mode == MS_RISE) ? 1 : 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_landed(input int budget);
      int c = 0;
      while (falling && c < budget) begin step(); c++; end
      check("land_timeout", int'(falling), 0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int fall_exp[8];
      int idx;
      int last;
      int c;
      bit pulse;
      fall_exp = '{501, 503, 506, 510, 515, 521, 528, 536};

      // Reset held with live inputs
      xpos_in = 12'd100; ypos_in = 12'd200; rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_x", int'(xpos_out), 0);
         check("reset_y", int'(ypos_out), 0);
         check("reset_falling", int'(falling), 0);
      end
      rst = 1'b1;
      step();
      check("release_x", int'(xpos_out), 100);
      check("release_y", int'(ypos_out), 200);

      // Tracking with clamp
      xpos_in = 12'd300; ypos_in = 12'd700;
      step();
      check("track_x", int'(xpos_out), 300);
      check("track_y_clamp", int'(ypos_out), 536);

      // Fall from y=500 with a second press mid-fall
      ypos_in = 12'd500; mouse_left = 1'b1;
      step();
      check("press_y", int'(ypos_out), 500);
      check("press_falling", int'(falling), 1);
      mouse_left = 1'b0;
      ypos_in = 12'd100;   // must be ignored while falling
      idx = 0; last = 500; c = 0; pulse = 1'b0;
      while (idx < 8 && c < 200) begin
         step(); c++;
         if (pulse) begin mouse_left = 1'b0; pulse = 1'b0; end
         if (int'(ypos_out) != last) begin
            check("fall_y", int'(ypos_out), fall_exp[idx]);
            last = int'(ypos_out);
            idx++;
            if (idx == 2) begin mouse_left = 1'b1; pulse = 1'b1; end
         end
      end
      mouse_left = 1'b0;
      check("fall_steps", idx, 8);
`ifdef RECT_BOUNCE_EN
      wait_landed(4000);
`else
      check("landed_falling", int'(falling), 0);
      repeat (80) step();
      check("landed_hold_y", int'(ypos_out), 536);
      check("landed_hold_x", int'(xpos_out), 300);
`endif

      // Press in LANDED: held this cycle, tracking on the next
      xpos_in = 12'd50; ypos_in = 12'd60; mouse_left = 1'b1;
      step();
      check("unland_hold_y", int'(ypos_out), 536);
      mouse_left = 1'b0;
      step();
      check("retrack_x", int'(xpos_out), 50);
      check("retrack_y", int'(ypos_out), 60);

      // Reset in the middle of a fall
      ypos_in = 12'd500; mouse_left = 1'b1;
      step();
      mouse_left = 1'b0;
      c = 0;
      while (int'(ypos_out) != 506 && c < 100) begin step(); c++; end
      check("midfall_y", int'(ypos_out), 506);
      rst = 1'b0;
      #1;
      check("midfall_rst_x", int'(xpos_out), 0);
      check("midfall_rst_y", int'(ypos_out), 0);
      check("midfall_rst_falling", int'(falling), 0);
      step(); step();
      rst = 1'b1; xpos_in = 12'd77; ypos_in = 12'd88;
      step();
      check("post_rst_x", int'(xpos_out), 77);
      check("post_rst_y", int'(ypos_out), 88);

`ifdef RECT_BOUNCE_EN
      // Drop from the top: first contact, then rise 16 then 15
      ypos_in = 12'd0; step();
      mouse_left = 1'b1; step(); mouse_left = 1'b0;
      c = 0;
      while (int'(ypos_out) != 536 && c < 1000) begin step(); c++; end
      check("bounce_contact", int'(ypos_out), 536);
      while (int'(ypos_out) == 536 && c < 1000) begin step(); c++; end
      check("bounce_rise1", int'(ypos_out), 520);
      while (int'(ypos_out) == 520 && c < 1000) begin step(); c++; end
      check("bounce_rise2", int'(ypos_out), 505);
      wait_landed(20000);
      check("bounce_final_y", int'(ypos_out), 536);
`endif

      repeat (4) step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
